// File: rtl/dbus_mmio_resp_if.sv
// darkriscv data-bus MMIO port bundle: core-side bus signals plus the TX byte stream.
// The core/bench drives through "master"; the responder connects through "slave".
interface dbus_mmio_resp_if;
    logic [31:0] DADDR;
    logic [31:0] DATAI;
    logic [31:0] DATAO;
    logic [3:0]  BE;
    logic        WR;
    logic        RD;
    logic        HLT;
    logic [7:0]  TXD;
    logic        TXV;
    logic        TXR;
    logic        IRQ;

    modport master (
        output DADDR, DATAI, BE, WR, RD, TXR,
        input  DATAO, HLT, TXD, TXV, IRQ
    );

    modport slave (
        input  DADDR, DATAI, BE, WR, RD, TXR,
        output DATAO, HLT, TXD, TXV, IRQ
    );
endinterface

// File: rtl/dbus_mmio_resp.sv
// MMIO responder for the darkriscv data bus: ID, CTRL/STATUS, TX byte FIFO with stream drain.
// Optional compare timer with interrupt is built only when MMIO_TIMER_EN is defined.
module dbus_mmio_resp #(
    parameter logic [31:0] BASE       = 32'h0000_0400,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] ID         = 32'h4D4D_494F
) (
    input  logic           CLK,
    input  logic           RES_N,
    dbus_mmio_resp_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    localparam logic [5:0] IDX_ID     = 6'd0;
    localparam logic [5:0] IDX_CTRL   = 6'd1;
    localparam logic [5:0] IDX_TXDATA = 6'd2;
    localparam logic [5:0] IDX_STATUS = 6'd3;
    localparam logic [5:0] IDX_TIMER  = 6'd4;
    localparam logic [5:0] IDX_CMP    = 6'd5;

    logic          sel_s;
    logic [5:0]    idx_s;
    logic          wr_sel_s;
    logic          tx_wr_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          full_s;
    logic          empty_s;
    logic          txv_s;
    logic          tif_s;
    logic          irq_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    logic [1:0]    ctrl_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [31:0]   datao_r;

    assign sel_s    = (bus.DADDR[31:8] == BASE[31:8]);
    assign idx_s    = bus.DADDR[7:2];
    assign wr_sel_s = bus.WR & sel_s;
    assign full_s   = (level_r == DEPTH_L);
    assign empty_s  = (level_r == {LW{1'b0}});
    assign txv_s    = ~empty_s;

    // Full-FIFO refusal uses the registered level, so a same-cycle pop never frees a slot early.
    assign tx_wr_s  = wr_sel_s & bus.BE[0] & (idx_s == IDX_TXDATA);
    assign push_s   = tx_wr_s & ~full_s;
    assign pop_s    = txv_s & bus.TXR;
    assign flush_s  = wr_sel_s & bus.BE[0] & (idx_s == IDX_CTRL) & bus.DATAI[2];

    assign bus.HLT  = tx_wr_s & full_s;
    assign bus.TXV  = txv_s;
    assign bus.TXD  = txv_s ? fifo_mem_r[rd_ptr_r] : 8'h00;
    assign bus.DATAO = datao_r;
    assign bus.IRQ  = irq_s;

    assign unused_s = ^{bus.DADDR[1:0], bus.DATAI[31:8], bus.BE[3:1]};

    // CTRL enable bits (FLUSH is a pulse and is not stored)
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            ctrl_r <= 2'b00;
        end else if (wr_sel_s && bus.BE[0] && (idx_s == IDX_CTRL)) begin
            ctrl_r <= bus.DATAI[1:0];
        end
    end

    // TX FIFO pointers, level and storage; a flush overrides any same-cycle pointer motion
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else if (flush_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.DATAI[7:0];
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_r + LW'(push_s) - LW'(pop_s);
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] timer_r;
    logic [31:0] cmp_r;
    logic        tif_r;
    logic        irq_r;
    logic        tif_set_s;
    logic        tif_clr_s;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    assign tif_set_s = ctrl_r[0] & (timer_r == cmp_r);
    assign tif_clr_s = wr_sel_s & bus.BE[0] & (idx_s == IDX_STATUS) & bus.DATAI[2];
    assign tif_s     = tif_r;
    assign irq_s     = irq_r;

    // Compare timer, sticky match flag (set beats clear) and registered interrupt
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            timer_r <= 32'h0000_0000;
            cmp_r   <= 32'hFFFF_FFFF;
            tif_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            if (wr_sel_s && (idx_s == IDX_TIMER)) begin
                timer_r <= be_merge(timer_r, bus.DATAI, bus.BE);
            end else if (ctrl_r[0]) begin
                timer_r <= timer_r + 32'd1;
            end
            if (wr_sel_s && (idx_s == IDX_CMP)) begin
                cmp_r <= be_merge(cmp_r, bus.DATAI, bus.BE);
            end
            tif_r <= tif_set_s | (tif_r & ~tif_clr_s);
            irq_r <= tif_r & ctrl_r[1];
        end
    end
`else
    assign tif_s = 1'b0;
    assign irq_s = 1'b0;
`endif

    // Register read mux; unmapped offsets return zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (idx_s)
            IDX_ID:     rdata_s = ID;
            IDX_CTRL:   rdata_s = {30'h0000_0000, ctrl_r};
            IDX_STATUS: rdata_s = {16'h0000, 8'(level_r), 5'b00000, tif_s, full_s, empty_s};
`ifdef MMIO_TIMER_EN
            IDX_TIMER:  rdata_s = timer_r;
            IDX_CMP:    rdata_s = cmp_r;
`endif
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Read data register: loaded on a selected read, cleared on every other cycle
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            datao_r <= 32'h0000_0000;
        end else if (bus.RD && sel_s) begin
            datao_r <= rdata_s;
        end else begin
            datao_r <= 32'h0000_0000;
        end
    end
endmodule

// File: tb/tb_dbus_mmio_resp.sv
// Randomized self-checking bench for dbus_mmio_resp against a queue-based reference model.
module tb_dbus_mmio_resp;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam int          DEPTH = 8;
    localparam logic [31:0] ID    = 32'h4D4D_494F;
`ifdef MMIO_TIMER_EN
    localparam logic        TEN_BUILD = 1'b1;
`else
    localparam logic        TEN_BUILD = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RES_N = 1'b0;

    dbus_mmio_resp_if bus();

    dbus_mmio_resp #(.BASE(BASE), .FIFO_DEPTH(DEPTH), .ID(ID)) dut (
        .CLK   (CLK),
        .RES_N (RES_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_q[$];
    logic        m_ten, m_ien, m_tif, m_irq;
    logic [31:0] m_timer, m_cmp, m_datao;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ten = 1'b0; m_ien = 1'b0; m_tif = 1'b0; m_irq = 1'b0;
        m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_datao = 32'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        case (idx)
            6'd0: return ID;
            6'd1: return {30'b0, m_ien, m_ten};
            6'd3: return {16'b0, 8'(m_q.size()), 5'b0, m_tif, (m_q.size() == DEPTH), (m_q.size() == 0)};
`ifdef MMIO_TIMER_EN
            6'd4: return m_timer;
            6'd5: return m_cmp;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive at the falling edge, check HLT, advance model, check registered outputs.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic wr, input logic rd, input logic txr);
        logic        sel, w, hlt_e, push, pop, fl, clr, tif_n;
        logic [5:0]  idx;
        logic [31:0] rv;
        sel   = (a[31:8] == BASE[31:8]);
        idx   = a[7:2];
        w     = wr & sel;
        rv    = m_read(idx);
        hlt_e = w & be[0] & (idx == 6'd2) & (m_q.size() == DEPTH);
        bus.DADDR = a; bus.DATAI = d; bus.BE = be; bus.WR = wr; bus.RD = rd; bus.TXR = txr;
        #1;
        chk("hlt", {31'b0, bus.HLT}, {31'b0, hlt_e});
        push  = w & be[0] & (idx == 6'd2) & (m_q.size() < DEPTH);
        pop   = (m_q.size() != 0) & txr;
        fl    = w & be[0] & (idx == 6'd1) & d[2];
        clr   = w & be[0] & (idx == 6'd3) & d[2];
        tif_n = 1'b0;
`ifdef MMIO_TIMER_EN
        tif_n = (m_ten && (m_timer == m_cmp)) || (m_tif && !clr);
        m_irq = m_tif & m_ien;
        if (w && idx == 6'd4) m_timer = merge(m_timer, d, be);
        else if (m_ten)       m_timer = m_timer + 32'd1;
        if (w && idx == 6'd5) m_cmp = merge(m_cmp, d, be);
`endif
        m_tif = tif_n;
        if (w && be[0] && idx == 6'd1) begin
            m_ten = d[0];
            m_ien = d[1];
        end
        m_datao = (rd && sel) ? rv : 32'h0;
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(d[7:0]);
        if (fl)   m_q.delete();
        @(negedge CLK);
        chk("datao", bus.DATAO, m_datao);
        chk("txv", {31'b0, bus.TXV}, {31'b0, (m_q.size() != 0)});
        chk("txd", {24'b0, bus.TXD}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
        chk("irq", {31'b0, bus.IRQ}, {31'b0, m_irq});
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic txr);
        cyc(a, d, be, 1'b1, 1'b0, txr);
    endtask

    task automatic rd_reg(input logic [31:0] a, input logic txr);
        cyc(a, 32'h0, 4'hF, 1'b0, 1'b1, txr);
    endtask

    task automatic idle(input logic txr);
        cyc(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, txr);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [5:0]  idx;
        logic [1:0]  op;
        bus.DADDR = 32'h0; bus.DATAI = 32'h0; bus.BE = 4'h0;
        bus.WR = 1'b0; bus.RD = 1'b0; bus.TXR = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_datao", bus.DATAO, 32'h0);
        chk("rst_hlt", {31'b0, bus.HLT}, 32'h0);
        chk("rst_txv", {31'b0, bus.TXV}, 32'h0);
        chk("rst_txd", {24'b0, bus.TXD}, 32'h0);
        chk("rst_irq", {31'b0, bus.IRQ}, 32'h0);
        RES_N = 1'b1;

        rd_reg(32'h400, 1'b0);
        chk("id", bus.DATAO, 32'h4D4D_494F);

        // Byte enables on CMP and on TXDATA
        wr_reg(32'h414, 32'hAABB_CCDD, 4'b0011, 1'b0);
        rd_reg(32'h414, 1'b0);
        chk("cmp_be", bus.DATAO, TEN_BUILD ? 32'hFFFF_CCDD : 32'h0);
        wr_reg(32'h408, 32'h55, 4'b1110, 1'b0);
        rd_reg(32'h40C, 1'b0);
        chk("tx_be_nopush", bus.DATAO, 32'h1);

        // Fill, stall, pop-frees-slot, drain
        for (int i = 0; i < 8; i++) wr_reg(32'h408, 32'h11 + i, 4'h1, 1'b0);
        rd_reg(32'h40C, 1'b0);
        chk("stat_full", bus.DATAO, 32'h0802);
        wr_reg(32'h408, 32'h19, 4'h1, 1'b0);
        chk("hlt_held", {31'b0, bus.HLT}, 32'h1);
        wr_reg(32'h408, 32'h19, 4'h1, 1'b1);
        wr_reg(32'h408, 32'h19, 4'h1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("txd_seq", {24'b0, bus.TXD}, 32'h12 + i);
            idle(1'b1);
        end
        chk("drained_txv", {31'b0, bus.TXV}, 32'h0);

        // Back-pressure with toggling ready
        for (int i = 0; i < 3; i++) wr_reg(32'h408, 32'hA0 + i, 4'h1, 1'b0);
        for (int i = 0; i < 6; i++) idle((i % 2) == 0);
        chk("bp_txv", {31'b0, bus.TXV}, 32'h0);
        rd_reg(32'h40C, 1'b0);
        chk("bp_status", bus.DATAO, 32'h1);

        // Timer: match, clear, set-beats-clear
        wr_reg(32'h414, 32'd5, 4'hF, 1'b0);
        wr_reg(32'h410, 32'd0, 4'hF, 1'b0);
        wr_reg(32'h404, 32'd3, 4'h1, 1'b0);
        repeat (10) idle(1'b0);
        chk("irq_up", {31'b0, bus.IRQ}, {31'b0, TEN_BUILD});
        wr_reg(32'h40C, 32'h4, 4'h1, 1'b0);
        idle(1'b0);
        chk("irq_clr", {31'b0, bus.IRQ}, 32'h0);
        wr_reg(32'h414, 32'd100, 4'hF, 1'b0);
        wr_reg(32'h410, 32'd100, 4'hF, 1'b0);
        wr_reg(32'h40C, 32'h4, 4'h1, 1'b0);
        rd_reg(32'h40C, 1'b0);
        chk("tif_set_wins", {31'b0, bus.DATAO[2]}, {31'b0, TEN_BUILD});
        wr_reg(32'h404, 32'h0, 4'h1, 1'b0);
        wr_reg(32'h40C, 32'h4, 4'h1, 1'b0);

        // Flush together with a pop handshake
        for (int i = 0; i < 4; i++) wr_reg(32'h408, 32'hC0 + i, 4'h1, 1'b0);
        chk("flush_head", {24'b0, bus.TXD}, 32'hC0);
        wr_reg(32'h404, 32'h4, 4'h1, 1'b1);
        chk("flush_txv", {31'b0, bus.TXV}, 32'h0);
        rd_reg(32'h40C, 1'b0);
        chk("flush_status", bus.DATAO, 32'h1);

        // Reset while a push is stalled on a full FIFO
        for (int i = 0; i < 8; i++) wr_reg(32'h408, 32'h30 + i, 4'h1, 1'b0);
        wr_reg(32'h408, 32'h99, 4'h1, 1'b0);
        RES_N = 1'b0;
        #1;
        chk("mid_rst_hlt", {31'b0, bus.HLT}, 32'h0);
        chk("mid_rst_txv", {31'b0, bus.TXV}, 32'h0);
        model_reset();
        @(negedge CLK);
        bus.WR = 1'b0; bus.RD = 1'b0; bus.DADDR = 32'h0; bus.BE = 4'h0;
        @(negedge CLK);
        RES_N = 1'b1;
        rd_reg(32'h40C, 1'b0);
        chk("post_rst_status", bus.DATAO, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idx = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) idx = 6'd2;
            a = {BASE[31:8], idx, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) a[31:8] = BASE[31:8] + 24'd1;
            d = $urandom;
            if (idx == 6'd1 && $urandom_range(0, 7) != 0) d[2] = 1'b0;
            op = 2'($urandom_range(0, 3));
            cyc(a, d, 4'($urandom_range(0, 15)), op[1], (op == 2'd1),
                ($urandom_range(0, 3) < ((n / 128) % 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dbus_mmio_resp.md
# dbus_mmio_resp

Memory-mapped I/O responder on the darkriscv data bus. It decodes DADDR/WR/RD/BE from the core and provides the following:
- an ID register;
- a control/status pair;
- an 8-entry transmit byte FIFO drained over a valid/ready stream;
- an optional 32-bit compare timer with interrupt.

It sits beside the data RAM. Its HLT output stalls the core when a TX push finds the FIFO full.

## Interface
- BASE, 32'h0000_0400: window base; the block responds when DADDR[31:8]==BASE[31:8].
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of 2, minimum 2.
- ID, 32'h4D4D_494F: constant returned at offset 0x00.
- CLK  in  1  clock; all state updates on rising edge.
- RES_N  in  1  reset; asynchronous, active-low.
- DADDR  in  32  byte address from core.
- DATAI  in  32  write data from core.
- DATAO  out  32  registered read data to core.
- BE  in  4  byte enables.
- WR  in  1  write strobe.
- RD  in  1  read strobe.
- HLT  out  1  combinational stall request to core.
- TXD  out  8  stream data (FIFO head).
- TXV  out  1  stream valid.
- TXR  in  1  stream ready.
- IRQ  out  1  level interrupt.

## Operation
- Select: `sel = DADDR[31:8]==BASE[31:8]`; register index = DADDR[7:2]. Unmapped offsets read 0 and ignore writes.
- Register map:
  - 0x00 ID (RO).
  - 0x04 CTRL: [0] TEN, [1] IEN, [2] FLUSH (write-1 pulse, reads 0). Reset 0.
  - 0x08 TXDATA (WO, reads 0): push DATAI[7:0] when BE[0].
  - 0x0C STATUS: [0] EMPTY, [1] FULL, [2] TIF (W1C), [15:8] LEVEL (0..FIFO_DEPTH), rest 0.
  - 0x10 TIMER (RW): reset 0.
  - 0x14 CMP (RW): reset 32'hFFFF_FFFF.
- Byte-enabled writes: CTRL, TIMER and CMP update only the bytes whose BE bit is set.
- FIFO state: write pointer, read pointer, LEVEL counter.
  - Push is accepted only when LEVEL<FIFO_DEPTH, using the registered LEVEL.
  - Pop occurs on TXV&TXR.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous accepted push and pop: LEVEL unchanged.
  - Push while full with a pop in the same cycle: the push is still refused and HLT stays asserted. It is accepted the next cycle.
- Stream outputs: TXV = LEVEL!=0. TXD = head entry when TXV, else 8'h00. TXD/TXV are stable while TXV&!TXR.
- FLUSH: pointers and LEVEL go to 0 at the next edge. A pop handshake in the same cycle completes and counts as delivered.
- HLT = sel & WR & BE[0] & offset==0x08 & FULL. HLT is never asserted for reads or other offsets.
- Timer, with TEN=1:
  - TIMER increments by 1 per cycle, wrapping 32'hFFFF_FFFF to 0.
  - A CPU write to TIMER takes priority over the increment for that cycle.
  - TIF sets when TEN & TIMER==CMP, evaluated on the pre-increment value.
- TIF clear: writing 1 to STATUS[2] with BE[0] clears TIF. Set and clear in the same cycle: set wins.
- IRQ = TIF & IEN, registered.

## Timing
- Read latency 1:
  - If RD & sel at edge N, DATAO holds the register value sampled at edge N from N+1.
  - Any other cycle loads 32'h0 into DATAO.
  - Reads have no side effects.
- Writes take effect at the edge where WR & sel (& !HLT for TXDATA).
  - STATUS LEVEL reflects a push on the following read.
- Pop to TXV: TXV falls the cycle after the last entry is popped. There are no bubbles while LEVEL>1.
- Reset values:
  - DATAO 0, HLT 0, TXD 0, TXV 0, IRQ 0.
  - LEVEL 0, pointers 0, CTRL 0, TIMER 0, CMP all-ones, TIF 0.
- Reset mid-operation: FIFO contents are discarded. An in-flight stalled push is lost, and HLT drops asynchronously with RES_N.

## Configuration
- MMIO_TIMER_EN defined: TIMER, CMP, TIF and IRQ are implemented as above.
- MMIO_TIMER_EN undefined:
  - No timer logic is synthesized.
  - Offsets 0x10/0x14 read 0 and ignore writes.
  - STATUS[2] reads 0.
  - IRQ is tied 0.
  - CTRL[1:0] remain writable but have no effect.

## Test plan
- Reset/ID: release RES_N, RD at 0x400 → DATAO=32'h4D4D494F one cycle later; all outputs 0 during reset.
- FIFO fill and stall: TXR=0, write 0x11..0x18 to 0x408 → STATUS=0x0802. Then:
  - ninth write 0x19 → HLT=1 held;
  - TXR=1 one cycle → 0x11 popped, 0x19 accepted the next cycle, HLT=0;
  - TXD sequence 0x12..0x19.
- Stream back-pressure: 3 pushes, TXR toggled 1/0 → TXD order preserved, TXV falls exactly one cycle after third pop, LEVEL=0, STATUS=0x0001.
- Byte enables: write 0xAABBCCDD to CMP with BE=4'b0011 → CMP reads 0xFFFFCCDD; TXDATA write with BE=4'b1110 → no push.
- Timer/IRQ (MMIO_TIMER_EN): CMP=5, CTRL=3 → TIF and IRQ rise when TIMER passes 5. Then:
  - write STATUS=0x4 → IRQ clears;
  - set and clear in the same cycle → TIF stays 1.
- Flush with handshake: LEVEL=4, TXR=1, write CTRL=0x4 → head byte delivered, LEVEL=0, TXV=0 next cycle.
